// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: cache instruction port, decode handshake, redirect and occupancy.
// master is the fetch_queue side, slave is the environment (cache/decode/redirect source).
interface fetch_queue_if #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0]  entry;
  logic                   ic_read;
  logic [ADDR_WIDTH-1:0]  ic_address;
  logic                   ic_resp_valid;
  logic [INSTR_WIDTH-1:0] ic_response;
  logic                   id_valid;
  logic                   id_ready;
  logic [ADDR_WIDTH-1:0]  id_pc;
  logic [INSTR_WIDTH-1:0] id_instr;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic [CNT_W-1:0]       fq_count;

  modport master (
    input  entry, ic_resp_valid, ic_response, id_ready, redirect_valid, redirect_pc,
    output ic_read, ic_address, id_valid, id_pc, id_instr, fq_count
  );

  modport slave (
    output entry, ic_resp_valid, ic_response, id_ready, redirect_valid, redirect_pc,
    input  ic_read, ic_address, id_valid, id_pc, id_instr, fq_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch sequencer with a small {pc, instr} buffer feeding decode.
// One outstanding cache request; redirects flush the buffer and drain any in-flight response.
module fetch_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   ic_read_q, ic_read_d;
  logic [ADDR_WIDTH-1:0]  ic_address_q, ic_address_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   id_valid_q, id_valid_d;
  logic [ADDR_WIDTH-1:0]  id_pc_q, id_pc_d;
  logic [INSTR_WIDTH-1:0] id_instr_q, id_instr_d;

  logic [ADDR_WIDTH-1:0]  mem_pc_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] mem_instr_q [DEPTH];

  logic                   push_c;
  logic                   pop_c;
  logic                   has_room_c;
  logic [ADDR_WIDTH-1:0]  target_c;
  logic [ADDR_WIDTH-1:0]  pc_inc_c;

  assign target_c = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign pc_inc_c = pc_q + ADDR_WIDTH'(4);

  // Next-state, FIFO bookkeeping and registered-output precompute.
  always_comb begin
    pop_c        = id_valid_q && bus.id_ready && !bus.redirect_valid;
    push_c       = (state_q == ST_REQ) && bus.ic_resp_valid && !bus.redirect_valid;
    state_d      = state_q;
    pc_d         = pc_q;
    ic_address_d = ic_address_q;
    wr_ptr_d     = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop_c);
    count_d      = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    has_room_c   = count_d < CNT_W'(DEPTH);

    if (bus.redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pc_d     = target_c;
      // A request still waiting on its response must be drained before refetching.
      if ((state_q == ST_REQ || state_q == ST_DROP) && !bus.ic_resp_valid) begin
        state_d = ST_DROP;
      end else begin
        state_d      = ST_REQ;
        ic_address_d = target_c;
      end
    end else begin
      case (state_q)
        ST_BOOT: begin
          pc_d         = bus.entry;
          ic_address_d = bus.entry;
          state_d      = ST_REQ;
        end
        ST_REQ: begin
          if (bus.ic_resp_valid) begin
            pc_d = pc_inc_c;
            if (has_room_c) begin
              ic_address_d = pc_inc_c;
            end else begin
              state_d = ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (has_room_c) begin
            state_d      = ST_REQ;
            ic_address_d = pc_q;
          end
        end
        ST_DROP: begin
          if (bus.ic_resp_valid) begin
            state_d      = ST_REQ;
            ic_address_d = pc_q;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end

    ic_read_d  = (state_d == ST_REQ) || (state_d == ST_DROP);
    id_valid_d = (count_d != '0);
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    // Head after this edge; the entry being written now is not yet in storage.
    if (count_d != '0) begin
      if (push_c && (rd_ptr_d == wr_ptr_q)) begin
        id_pc_d    = ic_address_q;
        id_instr_d = bus.ic_response;
      end else begin
        id_pc_d    = mem_pc_q[rd_ptr_d];
        id_instr_d = mem_instr_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= '0;
      ic_read_q    <= 1'b0;
      ic_address_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ic_read_q    <= ic_read_d;
      ic_address_q <= ic_address_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
    end
  end

  // Buffer storage; a response carries the address of the request it completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else if (push_c) begin
      mem_pc_q[wr_ptr_q]    <= ic_address_q;
      mem_instr_q[wr_ptr_q] <= bus.ic_response;
    end
  end

  assign bus.ic_read    = ic_read_q;
  assign bus.ic_address = ic_address_q;
  assign bus.id_valid   = id_valid_q;
  assign bus.id_pc      = id_pc_q;
  assign bus.id_instr   = id_instr_q;
  assign bus.fq_count   = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a cache model with random latency plus a
// sequential-PC reference for the decode stream, occupancy and request addresses.
module tb_fetch_queue;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned ADDR_WIDTH  = 64;
  localparam int unsigned INSTR_WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fq.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: next pc decode must see, next pc fetch must request, occupancy.
  logic [63:0] exp_id_pc;
  logic [63:0] f_pc;
  int          cnt_m;
  bit          booted;
  // Cache model state for the single outstanding request.
  bit          armed;
  bit          drop;
  int          lat;
  logic [63:0] arm_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
  endfunction

  task automatic model_reset(input logic [63:0] ent);
    exp_id_pc = ent;
    f_pc      = ent;
    cnt_m     = 0;
    booted    = 1'b0;
    armed     = 1'b0;
    drop      = 1'b0;
    lat       = 0;
    arm_addr  = '0;
  endtask

  // Called right after a falling edge: compare, then drive inputs for the next rising edge.
  task automatic evaluate(input int rdy_pct, input int redir_pct, input int max_lat);
    bit          pop, push, resp, redir, rdy;
    logic [63:0] tgt;
    if (booted) check_eq("ic_read", 64'(fq.ic_read), 64'(cnt_m < int'(DEPTH)));
    else        check_eq("boot_ic_read", 64'(fq.ic_read), 64'd0);
    check_eq("fq_count", 64'(fq.fq_count), 64'(cnt_m));
    check_eq("id_valid", 64'(fq.id_valid), 64'(cnt_m != 0));
    if (cnt_m != 0) begin
      check_eq("id_pc", fq.id_pc, exp_id_pc);
      check_eq("id_instr", 64'(fq.id_instr), 64'(instr_of(exp_id_pc)));
    end

    if (fq.ic_read && !armed) begin
      armed    = 1'b1;
      drop     = 1'b0;
      arm_addr = fq.ic_address;
      lat      = int'($urandom_range(max_lat, 0));
      check_eq("req_addr", fq.ic_address, f_pc);
    end else if (armed) begin
      check_eq("addr_stable", fq.ic_address, arm_addr);
    end

    rdy   = ($urandom_range(99, 0) < rdy_pct);
    redir = ($urandom_range(99, 0) < redir_pct);
    case ($urandom_range(3, 0))
      0:       tgt = 64'hffff_ffff_ffff_fff6;
      1:       tgt = 64'h0000_0000_0000_2002;
      default: tgt = {$urandom, $urandom};
    endcase
    resp = armed && (lat == 0);
    if (armed && lat != 0) lat--;

    fq.id_ready       = rdy;
    fq.redirect_valid = redir;
    fq.redirect_pc    = tgt;
    fq.ic_resp_valid  = resp;
    fq.ic_response    = resp ? instr_of(arm_addr) : $urandom;

    pop  = (cnt_m != 0) && rdy && !redir;
    push = resp && !drop && !redir;
    if (redir) begin
      cnt_m     = 0;
      f_pc      = {tgt[63:2], 2'b00};
      exp_id_pc = f_pc;
      if (armed) drop = 1'b1;
    end else begin
      cnt_m = cnt_m + int'(push) - int'(pop);
      if (pop)  exp_id_pc = exp_id_pc + 64'd4;
      if (push) f_pc = f_pc + 64'd4;
    end
    if (resp) armed = 1'b0;
    booted = 1'b1;
  endtask

  task automatic run(input int cycles, input int rdy_pct, input int redir_pct, input int max_lat);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      evaluate(rdy_pct, redir_pct, max_lat);
    end
  endtask

  task automatic release_reset(input logic [63:0] ent);
    fq.entry          = ent;
    fq.ic_resp_valid  = 1'b0;
    fq.ic_response    = '0;
    fq.id_ready       = 1'b0;
    fq.redirect_valid = 1'b0;
    fq.redirect_pc    = '0;
    model_reset(ent);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    evaluate(0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string phase);
    check_eq({phase, "_ic_read"},  64'(fq.ic_read), 64'd0);
    check_eq({phase, "_ic_addr"},  fq.ic_address, 64'd0);
    check_eq({phase, "_id_valid"}, 64'(fq.id_valid), 64'd0);
    check_eq({phase, "_id_pc"},    fq.id_pc, 64'd0);
    check_eq({phase, "_id_instr"}, 64'(fq.id_instr), 64'd0);
    check_eq({phase, "_fq_count"}, 64'(fq.fq_count), 64'd0);
  endtask

  initial begin
    fq.entry          = 64'h1000;
    fq.ic_resp_valid  = 1'b0;
    fq.ic_response    = '0;
    fq.id_ready       = 1'b0;
    fq.redirect_valid = 1'b0;
    fq.redirect_pc    = '0;
    #1;
    check_reset_outputs("por");

    release_reset(64'h1000);
    run(150, 100, 0, 0);   // back-to-back hits, decode always ready
    run(40, 0, 0, 0);      // fill to DEPTH and stall
    run(30, 30, 0, 0);     // trickle pops out of stall
    run(400, 50, 3, 2);
    run(400, 85, 12, 1);
    run(200, 100, 0, 0);

    // Asynchronous reset in the middle of a cycle with traffic running.
    run(3, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    release_reset(64'h0000_0000_8000_0000);
    run(400, 60, 5, 2);
    run(300, 95, 20, 0);
    run(100, 0, 10, 1);
    run(200, 70, 2, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
